// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and helpers for fifo_buffer and fifo_ram.
//   DEF_ADDR_WIDTH - default log2 depth
//   DEF_DATA_WIDTH - default word width
//   cnt_width()    - width of pointers/counts (one extra wrap bit)
package fifo_pkg;
    localparam int DEF_ADDR_WIDTH = 7;
    localparam int DEF_DATA_WIDTH = 8;

    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port RAM, 2^ADDR_WIDTH x DATA_WIDTH, registered read.
//   clk, rst        - clock; rst clears only the read register, not the array
//   we/waddr/wdata  - synchronous write port
//   re/raddr/rdata  - synchronous read port; rdata holds when re=0
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO with separate write/read sides.
//   clk, rst                  - clock, synchronous active-high reset
//   wr_en, wr_data            - write request and word
//   wr_full, wr_count         - full flag and occupancy (write side)
//   rd_en                     - read request
//   rd_data                   - registered read word, valid one cycle after accept
//   rd_empty, rd_count        - empty flag and occupancy (read side)
//   wr_overflow, rd_underflow - sticky error flags, present only with FIFO_ERR_FLAGS_EN
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             wr_full,
    output logic [cnt_width(ADDR_WIDTH)-1:0] wr_count,
    input  logic                             rd_en,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                             wr_overflow,
    output logic                             rd_underflow,
`endif
    output logic [cnt_width(ADDR_WIDTH)-1:0] rd_count
);
    localparam int CW = cnt_width(ADDR_WIDTH);

    logic [CW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, count;
    logic          wr_ok, rd_ok, full_n, empty_n;

    // Acceptance uses the registered flags, i.e. the state before the edge.
    // Gating with rst keeps X requests during reset from touching the RAM.
    always_comb begin
        wr_ok    = wr_en && !wr_full && !rst;
        rd_ok    = rd_en && !rd_empty && !rst;
        wr_ptr_n = wr_ptr + CW'(wr_ok);
        rd_ptr_n = rd_ptr + CW'(rd_ok);
        empty_n  = wr_ptr_n == rd_ptr_n;
        full_n   = (wr_ptr_n[ADDR_WIDTH] != rd_ptr_n[ADDR_WIDTH]) &&
                   (wr_ptr_n[ADDR_WIDTH-1:0] == rd_ptr_n[ADDR_WIDTH-1:0]);
    end

    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_full  <= 1'b0;
            rd_empty <= 1'b1;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            count    <= wr_ptr_n - rd_ptr_n;
            wr_full  <= full_n;
            rd_empty <= empty_n;
        end

    assign wr_count = count;
    assign rd_count = count;

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk)
        if (rst) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            wr_overflow  <= wr_overflow || (wr_en && wr_full);
            rd_underflow <= rd_underflow || (rd_en && rd_empty);
        end
`endif

    fifo_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ok),
        .waddr(wr_ptr[ADDR_WIDTH-1:0]),
        .wdata(wr_data),
        .re   (rd_ok),
        .raddr(rd_ptr[ADDR_WIDTH-1:0]),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed scoreboard bench for fifo_buffer (default 128 x 8).
module tb_fifo_buffer;
    localparam int DEPTH = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       wr_full, rd_empty;
    logic [7:0] wr_count, rd_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic       wr_overflow, rd_underflow;
`endif

    int         checks = 0;
    int         failures = 0;
    int         m_cnt = 0;
    logic [7:0] exp_rd = '0;
    logic [7:0] sb[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;

    fifo_buffer dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_full (wr_full),
        .wr_count(wr_count),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rd_empty(rd_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .wr_overflow (wr_overflow),
        .rd_underflow(rd_underflow),
`endif
        .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_cnt));
        chk({tag, ".rd_count"}, 32'(rd_count), 32'(m_cnt));
        chk({tag, ".wr_full"}, 32'(wr_full), 32'(m_cnt == DEPTH));
        chk({tag, ".rd_empty"}, 32'(rd_empty), 32'(m_cnt == 0));
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, ".wr_overflow"}, 32'(wr_overflow), 32'(m_ovf));
        chk({tag, ".rd_underflow"}, 32'(rd_underflow), 32'(m_udf));
`endif
    endtask

    // One clock: drive, predict from pre-edge model state, then check after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input string tag);
        logic wa, ra;
        wa = w && (m_cnt < DEPTH);
        ra = r && (m_cnt > 0);
        if (w && m_cnt == DEPTH) m_ovf = 1'b1;
        if (r && m_cnt == 0) m_udf = 1'b1;
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        if (ra) exp_rd = sb.pop_front();
        if (wa) sb.push_back(d);
        m_cnt = m_cnt + int'(wa) - int'(ra);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = 'x;
        chk_state(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 'x; rd_en = 'x;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        sb.delete(); m_cnt = 0; exp_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
        chk_state("reset");
    endtask

    initial begin
        do_reset();

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, "fill");
        chk("full_after_128", 32'(wr_full), 32'd1);
        step(1'b1, 8'd128, 1'b0, "write_when_full");
        chk("count_stays_128", 32'(wr_count), 32'd128);

        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain");
        step(1'b0, 8'h00, 1'b1, "read_when_empty");
        chk("rd_data_holds_127", 32'(rd_data), 32'd127);

`ifdef FIFO_ERR_FLAGS_EN
        step(1'b0, 8'h00, 1'b0, "sticky_idle");
        chk("ovf_sticky", 32'(wr_overflow), 32'd1);
        chk("udf_sticky", 32'(rd_underflow), 32'd1);
`endif

        do_reset();
        for (int i = 0; i < 2048; i++) step(1'b1, 8'(i), i >= 50, "stream");
        while (m_cnt > 0) step(1'b0, 8'h00, 1'b1, "stream_drain");
        chk("stream_last", 32'(rd_data), 32'hFF);

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, "to5");
        step(1'b1, 8'h55, 1'b1, "both_at_5");
        chk("count_5", 32'(wr_count), 32'd5);

        for (int i = 0; i < DEPTH - 5; i++) step(1'b1, 8'(i), 1'b0, "to_full");
        step(1'b1, 8'h77, 1'b1, "both_at_full");
        chk("count_127", 32'(rd_count), 32'd127);

        while (m_cnt > 0) step(1'b0, 8'h00, 1'b1, "to_empty");
        step(1'b1, 8'h3C, 1'b1, "both_at_empty");
        chk("count_1", 32'(wr_count), 32'd1);
        step(1'b0, 8'h00, 1'b1, "read_3c");

        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, "pre_midreset");
        do_reset();
        step(1'b0, 8'h00, 1'b1, "read_after_midreset");
        step(1'b1, 8'h99, 1'b0, "write_after_midreset");
        step(1'b0, 8'h00, 1'b1, "read_99");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
